// File: rtl/p2s_tx_ctrl.sv
// Transmit controller for the chat UART 10-bit frame shifter: round-robin pick
// between two character sources, then paced load / baud tick / end-of-frame strobes.
module p2s_tx_ctrl #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FRAME_BITS   = 10,
   parameter int CNT_W        = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       grant0,
   output logic       grant1,
   output logic [7:0] txData,
   output logic       load,
   output logic       transEn,
   output logic       srClock,
   output logic       charSent,
   output logic       busy
);

   localparam int BIT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STOP, DONE} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_baudCnt;
   logic [CNT_W-1:0] w_nextBaud;
   logic [BIT_W-1:0] r_bitCnt;
   logic [BIT_W-1:0] w_nextBit;
   logic             r_ptr;
   logic             w_nextPtr;
   logic             w_win;
   logic [7:0]       r_txData;
   logic [7:0]       w_nextTx;
   logic             w_grant0Nxt;
   logic             w_grant1Nxt;
   logic             r_grant0;
   logic             r_grant1;
   logic             r_load;
   logic             r_transEn;
   logic             r_srClock;
   logic             r_charSent;
   logic             r_busy;

   always_comb begin
      w_nextState = r_state;
      w_nextBaud  = r_baudCnt;
      w_nextBit   = r_bitCnt;
      w_nextPtr   = r_ptr;
      w_nextTx    = r_txData;
      w_grant0Nxt = 1'b0;
      w_grant1Nxt = 1'b0;
      // A lone requester always wins; the pointer only breaks ties.
      w_win       = (req0 && req1) ? r_ptr : req1;

      case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_nextState = LOAD;
               w_grant0Nxt = ~w_win;
               w_grant1Nxt = w_win;
               w_nextTx    = w_win ? data1 : data0;
               w_nextPtr   = ~w_win;
               w_nextBaud  = '0;
               w_nextBit   = '0;
            end
         end
         LOAD: begin
            w_nextState = SHIFT;
            w_nextBaud  = '0;
            w_nextBit   = '0;
         end
         SHIFT: begin
            if (r_baudCnt == BAUD_MAX) begin
               w_nextBaud = '0;
               w_nextBit  = r_bitCnt + 1'b1;
               if (r_bitCnt == LAST_BIT) begin
                  w_nextState = STOP;
               end
            end else begin
               w_nextBaud = r_baudCnt + 1'b1;
            end
         end
         STOP: begin
            // Hold the stop bit for one full bit time before signalling completion.
            if (r_baudCnt == BAUD_MAX) begin
               w_nextState = DONE;
               w_nextBaud  = '0;
            end else begin
               w_nextBaud = r_baudCnt + 1'b1;
            end
         end
         DONE: begin
            w_nextState = IDLE;
            w_nextBaud  = '0;
            w_nextBit   = '0;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Strobes are decoded from the upcoming state so every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_baudCnt  <= '0;
         r_bitCnt   <= '0;
         r_ptr      <= 1'b0;
         r_txData   <= '0;
         r_grant0   <= 1'b0;
         r_grant1   <= 1'b0;
         r_load     <= 1'b0;
         r_transEn  <= 1'b0;
         r_srClock  <= 1'b0;
         r_charSent <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_baudCnt  <= w_nextBaud;
         r_bitCnt   <= w_nextBit;
         r_ptr      <= w_nextPtr;
         r_txData   <= w_nextTx;
         r_grant0   <= w_grant0Nxt;
         r_grant1   <= w_grant1Nxt;
         r_load     <= (w_nextState == LOAD);
         r_transEn  <= (w_nextState == SHIFT);
         r_srClock  <= (w_nextState == SHIFT) && (w_nextBaud == BAUD_MAX);
         r_charSent <= (w_nextState == DONE);
         r_busy     <= (w_nextState != IDLE);
      end
   end

   assign grant0   = r_grant0;
   assign grant1   = r_grant1;
   assign txData   = r_txData;
   assign load     = r_load;
   assign transEn  = r_transEn;
   assign srClock  = r_srClock;
   assign charSent = r_charSent;
   assign busy     = r_busy;

endmodule
